// File: rtl/forwarding_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard control for NSRC source operands.
// Operands are resolved from MEM, WB or a per-operand shadow register that holds values retiring while EX is held.
module forwarding_hazard_unit #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int NSRC        = 2,
   parameter int STALL_LIMIT = 64
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     ex_valid,
   input  logic [NSRC*REG_AW-1:0]   ex_src,
   input  logic [NSRC-1:0]          ex_src_used,
   input  logic                     ex_advance,
   input  logic                     flush,
   input  logic                     mem_valid,
   input  logic                     mem_rfWEN,
   input  logic                     mem_memREN,
   input  logic [REG_AW-1:0]        mem_dest,
   input  logic [DATA_W-1:0]        mem_aluout,
   input  logic [DATA_W-1:0]        mem_ldat,
   input  logic                     dhit,
   input  logic                     wb_rfWEN,
   input  logic [REG_AW-1:0]        wb_dest,
   input  logic [DATA_W-1:0]        wb_wdat,
   output logic [NSRC*2-1:0]        fwd_sel,
   output logic [NSRC*DATA_W-1:0]   fwd_dat,
   output logic                     stall_ex,
   output logic                     hz_timeout,
   output logic [31:0]              stall_cnt
);

   // state  | meaning
   // IDLE   | no outstanding load; stalls only while a load-use hazard is visible
   // LDWAIT | load in MEM has not returned; EX held until dhit or flush

   localparam int WCNT_W = $clog2(STALL_LIMIT + 1);
   localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(STALL_LIMIT);

   localparam logic [1:0] SEL_STD    = 2'b00;
   localparam logic [1:0] SEL_MEM    = 2'b01;
   localparam logic [1:0] SEL_WB     = 2'b10;
   localparam logic [1:0] SEL_SHADOW = 2'b11;

   typedef enum logic {
      IDLE   = 1'b0,
      LDWAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
   logic                hz_q, hz_d;
   logic [31:0]         stall_cnt_q, stall_cnt_d;
   logic [NSRC-1:0]     shadow_v_q, shadow_v_d;
   logic [DATA_W-1:0]   shadow_q [NSRC];
   logic [DATA_W-1:0]   shadow_d [NSRC];

   logic [NSRC-1:0]     mem_hit, ld_hit, wb_hit, sh_hit;
   logic                ldhaz;
   logic                capture;
   logic                stall;

   genvar g;
   generate
      for (g = 0; g < NSRC; g++) begin : g_op
         logic [REG_AW-1:0] src;
         logic              live;
         logic              mem_dst_hit;
         logic [1:0]        sel;
         logic [DATA_W-1:0] dat;

         assign src         = ex_src[g*REG_AW +: REG_AW];
         assign live        = ex_valid & ex_src_used[g] & (src != '0);
         assign mem_dst_hit = live & mem_valid & mem_rfWEN & (mem_dest == src);
         // a load in MEM has no usable aluout, so it can only raise a hazard
         assign mem_hit[g]  = mem_dst_hit & ~mem_memREN;
         assign ld_hit[g]   = mem_dst_hit & mem_memREN;
         assign wb_hit[g]   = live & wb_rfWEN & (wb_dest == src);
         assign sh_hit[g]   = live & shadow_v_q[g];

         always_comb begin
            sel = SEL_STD;
            dat = '0;
            if (mem_hit[g]) begin
               sel = SEL_MEM;
               dat = mem_aluout;
            end else if (wb_hit[g]) begin
               sel = SEL_WB;
               dat = wb_wdat;
            end else if (sh_hit[g]) begin
               sel = SEL_SHADOW;
               dat = shadow_q[g];
            end
         end

         assign fwd_sel[g*2 +: 2]          = sel;
         assign fwd_dat[g*DATA_W +: DATA_W] = dat;
      end
   endgenerate

   assign ldhaz    = |ld_hit;
   assign wait_inc = (wait_cnt_q == WAIT_LIM) ? wait_cnt_q : wait_cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      hz_d       = hz_q;
      stall      = 1'b0;
      capture    = 1'b0;
      if (flush) begin
         state_d    = IDLE;
         wait_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ldhaz) begin
                  stall = 1'b1;
                  if (dhit) begin
                     capture = 1'b1;
                  end else begin
                     state_d    = LDWAIT;
                     wait_cnt_d = '0;
                  end
               end
            end
            LDWAIT: begin
               stall      = 1'b1;
               wait_cnt_d = wait_inc;
               if (wait_inc == WAIT_LIM) hz_d = 1'b1;
               if (dhit) begin
                  capture    = 1'b1;
                  state_d    = IDLE;
                  wait_cnt_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

   // dhit capture takes precedence over WB capture; leaving EX discards every shadow
   always_comb begin
      shadow_v_d = shadow_v_q;
      for (int i = 0; i < NSRC; i++) begin
         shadow_d[i] = shadow_q[i];
         if (capture && ld_hit[i]) begin
            shadow_d[i]   = mem_ldat;
            shadow_v_d[i] = 1'b1;
         end else if (!ex_advance && wb_hit[i]) begin
            shadow_d[i]   = wb_wdat;
            shadow_v_d[i] = 1'b1;
         end
      end
      if (ex_advance || flush) shadow_v_d = '0;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         hz_q        <= 1'b0;
         stall_cnt_q <= '0;
         shadow_v_q  <= '0;
         for (int i = 0; i < NSRC; i++) shadow_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         hz_q        <= hz_d;
         stall_cnt_q <= stall_cnt_d;
         shadow_v_q  <= shadow_v_d;
         for (int i = 0; i < NSRC; i++) shadow_q[i] <= shadow_d[i];
      end
   end

   assign stall_ex   = stall;
   assign hz_timeout = hz_q;
   assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit: directed hazard scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_forwarding_hazard_unit;
   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NS  = 2;
   localparam int LIM = 64;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             ex_valid, ex_advance, flush;
   logic [NS*AW-1:0] ex_src;
   logic [NS-1:0]    ex_src_used;
   logic             mem_valid, mem_rfWEN, mem_memREN, dhit, wb_rfWEN;
   logic [AW-1:0]    mem_dest, wb_dest;
   logic [DW-1:0]    mem_aluout, mem_ldat, wb_wdat;
   logic [NS*2-1:0]  fwd_sel;
   logic [NS*DW-1:0] fwd_dat;
   logic             stall_ex, hz_timeout;
   logic [31:0]      stall_cnt;

   forwarding_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NSRC(NS), .STALL_LIMIT(LIM)) dut (
      .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_src(ex_src), .ex_src_used(ex_src_used),
      .ex_advance(ex_advance), .flush(flush), .mem_valid(mem_valid), .mem_rfWEN(mem_rfWEN),
      .mem_memREN(mem_memREN), .mem_dest(mem_dest), .mem_aluout(mem_aluout), .mem_ldat(mem_ldat),
      .dhit(dhit), .wb_rfWEN(wb_rfWEN), .wb_dest(wb_dest), .wb_wdat(wb_wdat),
      .fwd_sel(fwd_sel), .fwd_dat(fwd_dat), .stall_ex(stall_ex), .hz_timeout(hz_timeout),
      .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // reference model: waiting flag, cycles waited, shadow contents, sticky timeout, stall count
   bit          m_ldw, n_ldw;
   int          m_waited, n_waited;
   bit          m_sv [NS];
   bit          n_sv [NS];
   logic [31:0] m_sd [NS];
   logic [31:0] n_sd [NS];
   bit          m_to, n_to;
   longint      m_sc, n_sc;
   logic [NS*2-1:0]  e_sel;
   logic [NS*DW-1:0] e_dat;
   bit               e_stall;

   task automatic model_reset();
      m_ldw = 0; m_waited = 0; m_to = 0; m_sc = 0;
      for (int i = 0; i < NS; i++) begin m_sv[i] = 0; m_sd[i] = '0; end
   endtask

   task automatic model_eval();
      bit ld [NS];
      bit wbm [NS];
      bit ldhaz, cap;
      ldhaz = 0;
      e_sel = '0;
      e_dat = '0;
      for (int i = 0; i < NS; i++) begin
         logic [AW-1:0] src;
         bit live, memw;
         int s;
         src    = ex_src[i*AW +: AW];
         live   = ex_valid && ex_src_used[i] && (src != 0);
         memw   = live && mem_valid && mem_rfWEN && (mem_dest == src);
         ld[i]  = memw && mem_memREN;
         wbm[i] = live && wb_rfWEN && (wb_dest == src);
         if (ld[i]) ldhaz = 1;
         if (memw && !mem_memREN) s = 1;
         else if (wbm[i])         s = 2;
         else if (live && m_sv[i]) s = 3;
         else                     s = 0;
         e_sel[i*2 +: 2] = s[1:0];
         case (s)
            1:       e_dat[i*DW +: DW] = mem_aluout;
            2:       e_dat[i*DW +: DW] = wb_wdat;
            3:       e_dat[i*DW +: DW] = m_sd[i];
            default: e_dat[i*DW +: DW] = '0;
         endcase
      end
      e_stall = !flush && (m_ldw || ldhaz);
      cap     = !flush && dhit && (m_ldw || ldhaz);

      n_ldw = m_ldw; n_waited = m_waited; n_to = m_to;
      if (flush) begin
         n_ldw = 0; n_waited = 0;
      end else if (m_ldw) begin
         n_waited = (m_waited + 1 > LIM) ? LIM : m_waited + 1;
         if (n_waited == LIM) n_to = 1;
         if (dhit) begin n_ldw = 0; n_waited = 0; end
      end else if (ldhaz && !dhit) begin
         n_ldw = 1; n_waited = 0;
      end

      for (int i = 0; i < NS; i++) begin
         n_sv[i] = m_sv[i]; n_sd[i] = m_sd[i];
         if (flush || ex_advance) n_sv[i] = 0;
         else if (cap && ld[i]) begin n_sv[i] = 1; n_sd[i] = mem_ldat; end
         else if (wbm[i])       begin n_sv[i] = 1; n_sd[i] = wb_wdat; end
      end
      n_sc = (e_stall && m_sc < 64'hFFFF_FFFF) ? m_sc + 1 : m_sc;
   endtask

   task automatic model_commit();
      m_ldw = n_ldw; m_waited = n_waited; m_to = n_to; m_sc = n_sc;
      for (int i = 0; i < NS; i++) begin m_sv[i] = n_sv[i]; m_sd[i] = n_sd[i]; end
   endtask

   // entered just after a falling edge with inputs already applied
   task automatic step();
      #1;
      model_eval();
      chk("fwd_sel",    64'(fwd_sel),    64'(e_sel));
      chk("fwd_dat",    64'(fwd_dat),    64'(e_dat));
      chk("stall_ex",   64'(stall_ex),   64'(e_stall));
      chk("hz_timeout", 64'(hz_timeout), 64'(m_to));
      chk("stall_cnt",  64'(stall_cnt),  64'(m_sc[31:0]));
      @(posedge CLK);
      model_commit();
      @(negedge CLK);
   endtask

   task automatic quiet();
      ex_valid = 0; ex_src = '0; ex_src_used = '0; ex_advance = 1; flush = 0;
      mem_valid = 0; mem_rfWEN = 0; mem_memREN = 0; mem_dest = '0; mem_aluout = '0;
      mem_ldat = '0; dhit = 0; wb_rfWEN = 0; wb_dest = '0; wb_wdat = '0;
   endtask

   task automatic rand_inputs();
      ex_valid    = ($urandom_range(0, 9) < 8);
      ex_src      = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      ex_src_used = NS'($urandom_range(0, 3));
      ex_advance  = $urandom_range(0, 1);
      flush       = ($urandom_range(0, 19) == 0);
      mem_valid   = $urandom_range(0, 1);
      mem_rfWEN   = ($urandom_range(0, 3) != 0);
      mem_memREN  = ($urandom_range(0, 9) < 4);
      mem_dest    = AW'($urandom_range(0, 3));
      mem_aluout  = $urandom;
      mem_ldat    = $urandom;
      dhit        = ($urandom_range(0, 9) < 3);
      wb_rfWEN    = $urandom_range(0, 1);
      wb_dest     = AW'($urandom_range(0, 3));
      wb_wdat     = $urandom;
   endtask

   logic [31:0] base;

   initial begin
      quiet();
      nRST = 0;
      model_reset();
      #2;
      chk("rst_stall", 64'(stall_ex), 64'(0));
      chk("rst_sel",   64'(fwd_sel),  64'(0));
      chk("rst_hz",    64'(hz_timeout), 64'(0));
      chk("rst_scnt",  64'(stall_cnt),  64'(0));
      @(negedge CLK);
      nRST = 1;
      step();

      // ALU result in MEM forwards to rs with no stall
      ex_valid = 1; ex_src = {5'd0, 5'd3}; ex_src_used = 2'b01;
      mem_valid = 1; mem_rfWEN = 1; mem_memREN = 0; mem_dest = 5'd3; mem_aluout = 32'h1234_5678;
      #1;
      chk("t1_sel", 64'(fwd_sel[1:0]), 64'(2'b01));
      chk("t1_dat", 64'(fwd_dat[31:0]), 64'h1234_5678);
      chk("t1_stall", 64'(stall_ex), 64'(0));
      step();

      // MEM outranks WB; a $0 destination never forwards
      wb_rfWEN = 1; wb_dest = 5'd3; wb_wdat = 32'h0000_AAAA;
      #1;
      chk("t2_prio", 64'(fwd_sel[1:0]), 64'(2'b01));
      step();
      ex_src = {5'd0, 5'd0}; mem_dest = 5'd0; wb_rfWEN = 0;
      #1;
      chk("t2_r0", 64'(fwd_sel), 64'(0));
      step();

      // load-use on rt, dhit on the fourth cycle
      quiet();
      base = stall_cnt;
      ex_valid = 1; ex_advance = 0; ex_src = {5'd4, 5'd7}; ex_src_used = 2'b11;
      mem_valid = 1; mem_rfWEN = 1; mem_memREN = 1; mem_dest = 5'd4; mem_aluout = 32'h0BAD_0BAD;
      for (int c = 0; c < 3; c++) step();
      dhit = 1; mem_ldat = 32'hDEAD_BEEF;
      step();
      dhit = 0; mem_valid = 0;
      #1;
      chk("t3_pen", 64'(stall_cnt - base), 64'(4));
      chk("t3_stall", 64'(stall_ex), 64'(0));
      chk("t3_sel", 64'(fwd_sel[3:2]), 64'(2'b11));
      chk("t3_dat", 64'(fwd_dat[63:32]), 64'hDEAD_BEEF);
      step();
      ex_advance = 1;
      step();
      #1;
      chk("t3_clr", 64'(fwd_sel), 64'(0));
      step();

      // value retiring from WB while EX is held lands in the shadow
      quiet();
      ex_valid = 1; ex_advance = 0; ex_src = {5'd0, 5'd5}; ex_src_used = 2'b01;
      wb_rfWEN = 1; wb_dest = 5'd5; wb_wdat = 32'h55;
      step();
      wb_rfWEN = 0; wb_wdat = '0;
      #1;
      chk("t4_sel", 64'(fwd_sel[1:0]), 64'(2'b11));
      chk("t4_dat", 64'(fwd_dat[31:0]), 64'h55);
      step();
      ex_advance = 1;
      step();
      #1;
      chk("t4_clr", 64'(fwd_sel), 64'(0));
      step();

      // flush together with dhit in LDWAIT
      quiet();
      ex_valid = 1; ex_advance = 0; ex_src = {5'd6, 5'd0}; ex_src_used = 2'b10;
      mem_valid = 1; mem_rfWEN = 1; mem_memREN = 1; mem_dest = 5'd6;
      step();
      flush = 1; dhit = 1; mem_ldat = 32'hCAFE_F00D;
      #1;
      chk("t5_stall", 64'(stall_ex), 64'(0));
      step();
      flush = 0; dhit = 0; mem_valid = 0;
      #1;
      chk("t5_idle", 64'(stall_ex), 64'(0));
      chk("t5_shv", 64'(fwd_sel), 64'(0));
      step();

      for (int n = 0; n < 800; n++) begin
         rand_inputs();
         step();
      end

      // dhit withheld past the limit
      quiet();
      step();
      ex_valid = 1; ex_advance = 0; ex_src = {5'd0, 5'd9}; ex_src_used = 2'b01;
      mem_valid = 1; mem_rfWEN = 1; mem_memREN = 1; mem_dest = 5'd9;
      for (int c = 0; c < LIM + 1; c++) step();
      #1;
      chk("t6_hz", 64'(hz_timeout), 64'(1));
      for (int c = 0; c < 3; c++) step();
      #1;
      chk("t6_sticky", 64'(hz_timeout), 64'(1));
      chk("t6_stall", 64'(stall_ex), 64'(1));

      // asynchronous reset mid-LDWAIT
      #1;
      nRST = 0; ex_valid = 0;
      #1;
      model_reset();
      chk("t6_rst_stall", 64'(stall_ex), 64'(0));
      chk("t6_rst_hz",    64'(hz_timeout), 64'(0));
      chk("t6_rst_scnt",  64'(stall_cnt),  64'(0));
      chk("t6_rst_sel",   64'(fwd_sel),    64'(0));
      @(negedge CLK);
      nRST = 1;
      mem_valid = 0; ex_valid = 1;
      step();
      for (int n = 0; n < 200; n++) begin
         rand_inputs();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
